// File: rtl/systolic_input_buffer.sv
// Skewing input buffer for the left edge of a LANES-row systolic array.
// Streams one preloaded column per read cycle; lane r lags lane 0 by r cycles.
module systolic_input_buffer #(
  parameter int unsigned LANES  = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           read,
  output logic [LANES-1:0]               o_valid,
  output logic [LANES-1:0][DATA_W-1:0]   o_data
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [LANES][DEPTH];
  logic [AddrW-1:0]  rptr_q, rptr_d;

  // Matrix is reloaded on every reset and never written otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < LANES; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          mem_q[r][c] <= DATA_W'(16 * r + c);
        end
      end
    end
  end

  // Power-of-two depth lets the pointer wrap by natural overflow.
  always_comb begin
    rptr_d = rptr_q;
    if (read) begin
      rptr_d = rptr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
    end
  end

  // Per-lane chain: stage 0 is the issue stage, stage r drives the output.
  for (genvar r = 0; r < LANES; r++) begin : g_lane
    logic [r:0]             vld_q;
    logic [r:0][DATA_W-1:0] dat_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= read;
        dat_q[0] <= read ? mem_q[r][rptr_q] : '0;
        for (int s = 1; s <= r; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign o_valid[r] = vld_q[r];
    assign o_data[r]  = dat_q[r];
  end

endmodule

// File: tb/tb_systolic_input_buffer.sv
// Self-checking bench: directed plan steps plus random read/reset traffic,
// compared against a history-based model of issued columns.
module tb_systolic_input_buffer;

  localparam int LANES  = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         read;
  logic [LANES-1:0]             o_valid;
  logic [LANES-1:0][DATA_W-1:0] o_data;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit v;
    int col;
  } rec_t;

  // hist[k] is what was issued k edges ago (index 0 = most recent edge).
  rec_t hist[$];
  int   mdl_ptr;

  systolic_input_buffer #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .o_valid(o_valid),
    .o_data (o_data)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic rd, input logic rs);
    rec_t rec;
    if (rs) begin
      hist.delete();
      rec.v = 1'b0;
      rec.col = 0;
      for (int i = 0; i < LANES; i++) hist.push_front(rec);
      mdl_ptr = 0;
    end else begin
      rec.v = rd;
      rec.col = mdl_ptr;
      hist.push_front(rec);
      while (hist.size() > LANES) void'(hist.pop_back());
      if (rd) mdl_ptr = (mdl_ptr + 1) % DEPTH;
    end
  endfunction

  task automatic check(input string tag);
    logic              exp_v;
    logic [DATA_W-1:0] exp_d;
    for (int r = 0; r < LANES; r++) begin
      exp_v = hist[r].v;
      exp_d = exp_v ? DATA_W'(16 * r + hist[r].col) : '0;
      tests_run++;
      assert (o_valid[r] === exp_v) else begin
        tests_failed++;
        $error("FAIL %s valid lane%0d: got %b, want %b", tag, r, o_valid[r], exp_v);
      end
      tests_run++;
      assert (o_data[r] === exp_d) else begin
        tests_failed++;
        $error("FAIL %s data lane%0d: got %h, want %h", tag, r, o_data[r], exp_d);
      end
    end
  endtask

  task automatic step(input logic rd, input logic rs, input string tag);
    read = rd;
    rst  = rs;
    @(posedge clk);
    model_edge(rd, rs);
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    rec_t rec;
    rec.v = 1'b0;
    rec.col = 0;
    for (int i = 0; i < LANES; i++) hist.push_front(rec);
    mdl_ptr = 0;
    read = 1'b0;
    rst  = 1'b1;

    // Reset held with read asserted: nothing may be issued.
    step(1'b1, 1'b1, "reset");
    step(1'b1, 1'b1, "reset");

    // 3-cycle burst, then long idle drain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "burst");
    idle(17, "burst_idle");

    // Bubble pattern 1,0,1.
    step(1'b1, 1'b0, "bubble");
    step(1'b0, 1'b0, "bubble");
    step(1'b1, 1'b0, "bubble");
    idle(4, "bubble_drain");

    // Wrap: DEPTH+2 consecutive reads.
    step(1'b0, 1'b1, "wrap_rst");
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, "wrap");
    idle(4, "wrap_drain");

    // Pointer hold across idle gap.
    step(1'b0, 1'b1, "hold_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "hold_rd");
    idle(5, "hold_idle");
    step(1'b1, 1'b0, "hold_last");
    idle(4, "hold_drain");

    // Mid-stream reset while lane 2 still valid, then a fresh burst.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "mid_rd");
    step(1'b1, 1'b1, "mid_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "mid_burst");
    idle(4, "mid_drain");

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, ($urandom % 40) == 0, "random");
    end
    idle(4, "final_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/systolic_input_buffer.md
# systolic_input_buffer

Skewing input buffer feeding the left edge of the CNN accelerator's 3-row systolic array. It holds a preloaded 3-lane × DEPTH-column byte matrix and streams one column per cycle while `read` is high. Lane r is delayed r cycles relative to lane 0, producing the diagonal wavefront the PE array requires. Each lane carries its own valid flag.

## Interface
- `LANES`, 3: number of output lanes (array rows).
- `DATA_W`, 8: bits per element.
- `DEPTH`, 8: columns stored per lane. `DEPTH` must be a power of two, ≥ 2.
- `clk` input 1: single clock. All logic is posedge.
- `rst` input 1: reset, synchronous, active-high.
- `read` input 1: stream-enable. A column is issued on each posedge where `read`=1.
- `o_valid` output [LANES-1:0]: bit r=1 means `o_data[r]` holds a valid element.
- `o_data` output [LANES-1:0][DATA_W-1:0], packed: element for lane r.

## Operation
- Storage `mem[r][c]`, r<LANES, c<DEPTH.
  - Loaded on reset with `mem[r][c] = 8'h10*r + c`, truncated to DATA_W.
  - There is no write port. Contents are constant outside reset.
- Read pointer `rptr` has width log2(DEPTH) and resets to 0.
- On each posedge with `read`=1:
  - Column `rptr` is captured into the issue stage, with valid=1.
  - `rptr` increments, wrapping from DEPTH-1 to 0. No stop at the end and no error.
- On a posedge with `read`=0:
  - The issue stage captures valid=0 and data=0.
  - `rptr` holds its value.
- Skew pipeline:
  - Lane r passes through r additional register stages after the issue stage: lane 0 has 0 extra, lane 1 has 1, lane 2 has 2.
  - Each stage carries {valid, data}.
- Output rule: `o_data[r]` is 0 whenever `o_valid[r]`=0. Invalid slots never expose stale data.
- Gaps in `read` propagate as bubbles. The pipeline keeps shifting regardless of `read`, so issued columns always drain.
- The block has no output backpressure.

## Timing
- Reset, applied on a posedge with `rst`=1:
  - `o_valid`=0 and all `o_data`=0.
  - All skew stages are cleared.
  - `rptr`=0 and `mem` is reloaded.
  - `rst` overrides `read`.
- Reset mid-stream: all in-flight elements are discarded. The next read after reset restarts at column 0.
- Latency: if `read` is sampled high at edge k, lane r presents that column's element after edge k+r. It is stable from edge k+r until edge k+r+1.
- Lane 0 is therefore registered with 1-cycle latency from `read`, with no combinational path from `read` to the outputs.
- A burst of B consecutive read cycles produces B valid beats on each lane.
  - Lane r's beats start r cycles after lane 0's.
  - The final beat on lane LANES-1 ends LANES-1 cycles after lane 0's final beat.
- Pointer wrap and reads spanning the wrap need no special handling. Column DEPTH-1 is followed directly by column 0.

## Test plan
- **Reset:** hold `rst`=1 for 2 edges with `read`=1 -> `o_valid`=000, `o_data`={00,00,00}, and no beats are emitted.
- **3-cycle burst after reset:** `read`=1 for edges 1–3 -> expected (`o_valid`; lane0, lane1, lane2) after each edge:
  - edge 1: 001; 00, 00, 00
  - edge 2: 011; 01, 10, 00
  - edge 3: 111; 02, 11, 20
  - edge 4: 110; 00, 12, 21
  - edge 5: 100; 00, 00, 22
  - edge 6 and later: 000
  - Holds for 15+ idle cycles.
- **Bubble:** `read` pattern 1,0,1 -> lane 0 valid 1,0,1 with data 00, 00, 01. Lane 2 shows the same pattern 2 cycles later with data 20, 00, 21.
- **Wrap:** hold `read` for DEPTH+2 = 10 cycles -> lane 0 emits 00..07 then 00, 01. Lane 1 emits 10..17 then 10, 11, delayed by 1.
- **Pointer hold across idle:** read 3 cycles, idle 5 cycles, read 1 cycle -> the last beat is column 3: lane 0=03, lane 1=13, lane 2=23 on successive cycles.
- **Mid-stream reset:** assert `rst` for 1 edge while lane 2 is still valid -> all outputs are 0 after that edge. A new burst starts at column 0.
